// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a holding register (TDR) in front of the line shifter.
// Optional parity bit when UART_TX_PARITY_EN is defined (adds parameter PARITY_ODD).
module uart_tx #(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned UART_BPS = 115200
`ifdef UART_TX_PARITY_EN
  ,
  parameter bit          PARITY_ODD = 1'b0
`endif
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       TX_WE,
  input  logic [7:0] TDR,
  output logic       TXE,
  output logic       TX_BUSY,
  output logic       TX_DONE,
  output logic       PIN_UART_TX
);

  localparam int unsigned BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int unsigned CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       hold_q, hold_d;
  logic [7:0]       shift_q, shift_d;
  logic             txe_q, txe_d;
  logic             pin_q, pin_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end;

  // State and datapath registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      hold_q  <= '0;
      shift_q <= '0;
      txe_q   <= 1'b1;
      pin_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      hold_q  <= hold_d;
      shift_q <= shift_d;
      txe_q   <= txe_d;
      pin_q   <= pin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bit_end = (cnt_q == CNT_LAST);

  // Next state: write acceptance, holding->shifter transfer, bit sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    hold_d  = hold_q;
    shift_d = shift_q;
    txe_d   = txe_q;

    if (TX_WE && txe_q) begin
      hold_d = TDR;
      txe_d  = 1'b0;
    end

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!txe_q) begin
          shift_d = hold_q;
          txe_d   = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          // A queued byte chains straight into the next start bit
          if (!txe_q) begin
            shift_d = hold_q;
            txe_d   = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so they line up with it
  always_comb begin
    pin_d  = 1'b1;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP) && (cnt_d == CNT_LAST);
    case (state_d)
      S_IDLE:   pin_d = 1'b1;
      S_START:  pin_d = 1'b0;
      S_DATA:   pin_d = shift_d[bit_d];
`ifdef UART_TX_PARITY_EN
      S_PARITY: pin_d = (^shift_d) ^ PARITY_ODD;
`endif
      S_STOP:   pin_d = 1'b1;
      default:  pin_d = 1'b1;
    endcase
  end

  assign TXE         = txe_q;
  assign TX_BUSY     = busy_q;
  assign TX_DONE     = done_q;
  assign PIN_UART_TX = pin_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx at BPS_CNT=10 (1 MHz clock, 100 kbaud).
module tb_uart_tx;

  localparam int unsigned BPS = 10;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_ODD = 1'b0;
`endif

  logic       CLK;
  logic       RST_N;
  logic       TX_WE;
  logic [7:0] TDR;
  logic       TXE;
  logic       TX_BUSY;
  logic       TX_DONE;
  logic       PIN_UART_TX;

  int n_chk;
  int n_bad;

  uart_tx #(
    .CLK_FREQ(1000000),
    .UART_BPS(100000)
`ifdef UART_TX_PARITY_EN
    ,
    .PARITY_ODD(PAR_ODD)
`endif
  ) u_dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .TX_WE      (TX_WE),
    .TDR        (TDR),
    .TXE        (TXE),
    .TX_BUSY    (TX_BUSY),
    .TX_DONE    (TX_DONE),
    .PIN_UART_TX(PIN_UART_TX)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Leaves the caller at the negedge right after the accepting edge
  task automatic write_byte(input logic [7:0] b);
    @(negedge CLK);
    TX_WE = 1'b1;
    TDR   = b;
    @(negedge CLK);
    TX_WE = 1'b0;
    check("pre_start_pin", 32'(PIN_UART_TX), 32'd1);
    check("txe_after_wr", 32'(TXE), 32'd0);
  endtask

  // Checks one full frame cycle by cycle, starting from the next negedge
  task automatic check_frame(input logic [7:0] b);
    logic [10:0] bits;
    int          nb;
    bits    = '0;
    bits[0] = 1'b0;
    bits[8:1] = b;
`ifdef UART_TX_PARITY_EN
    bits[9]  = (^b) ^ PAR_ODD;
    bits[10] = 1'b1;
    nb = 11;
`else
    bits[9] = 1'b1;
    nb = 10;
`endif
    for (int i = 0; i < nb; i++) begin
      for (int c = 0; c < int'(BPS); c++) begin
        @(negedge CLK);
        check("pin", 32'(PIN_UART_TX), 32'(bits[i]));
        check("busy", 32'(TX_BUSY), 32'd1);
        check("done", 32'(TX_DONE), 32'((i == nb - 1) && (c == int'(BPS) - 1)));
      end
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge CLK);
    check(tag, {29'd0, PIN_UART_TX, TX_BUSY, TX_DONE}, {29'd0, 1'b1, 1'b0, 1'b0});
    check("idle_txe", 32'(TXE), 32'd1);
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    RST_N = 1'b0;
    TX_WE = 1'b0;
    TDR   = 8'h00;

    // Reset idle
    repeat (3) @(negedge CLK);
    check("rst_pin", 32'(PIN_UART_TX), 32'd1);
    check("rst_txe", 32'(TXE), 32'd1);
    check("rst_busy", 32'(TX_BUSY), 32'd0);
    check("rst_done", 32'(TX_DONE), 32'd0);
    RST_N = 1'b1;
    for (int i = 0; i < 200; i++) check_idle("idle200");

    // Single byte 0xA5 (even parity bit 0)
    write_byte(8'hA5);
    check_frame(8'hA5);
    check_idle("after_a5");

    // Back-to-back 0x55 then 0x0F queued mid-frame
    write_byte(8'h55);
    fork
      begin
        check_frame(8'h55);
        check_frame(8'h0F);
      end
      begin
        repeat (20) @(negedge CLK);
        check("txe_mid", 32'(TXE), 32'd1);
        TX_WE = 1'b1;
        TDR   = 8'h0F;
        @(negedge CLK);
        TX_WE = 1'b0;
        check("txe_queued", 32'(TXE), 32'd0);
      end
    join
    check_idle("after_b2b");

    // Overrun: 0x33 offered while TXE=0 must be dropped
    write_byte(8'h11);
    fork
      begin
        check_frame(8'h11);
        check_frame(8'h22);
      end
      begin
        @(negedge CLK);
        TX_WE = 1'b1;
        TDR   = 8'h22;
        @(negedge CLK);
        check("txe_full", 32'(TXE), 32'd0);
        TDR = 8'h33;
        repeat (5) @(negedge CLK);
        TX_WE = 1'b0;
      end
    join
    check_idle("after_ovr");

    // Reset mid-frame during bit 3 of 0xFF
    write_byte(8'hFF);
    repeat (45) @(negedge CLK);
    check("bit3_busy", 32'(TX_BUSY), 32'd1);
    check("bit3_pin", 32'(PIN_UART_TX), 32'd1);
    #2;
    RST_N = 1'b0;
    #1;
    check("arst_pin", 32'(PIN_UART_TX), 32'd1);
    check("arst_txe", 32'(TXE), 32'd1);
    check("arst_busy", 32'(TX_BUSY), 32'd0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 5; i++) check_idle("post_rst");
    write_byte(8'h3C);
    check_frame(8'h3C);
    check_idle("after_3c");

`ifdef UART_TX_PARITY_EN
    // 0x07 has three ones: even parity bit 1
    write_byte(8'h07);
    check_frame(8'h07);
    check_idle("after_07");
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
